// File: rtl/sd_crc_pkg.sv
// Shared constants and types for the SD CRC engines (CMD CRC7, DAT CRC16-CCITT).
package sd_crc_pkg;

  localparam logic [6:0]  CRC7_POLY  = 7'h09;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam int unsigned SD_CMD_LEN = 40;
  localparam int unsigned SD_BLK_LEN = 4096;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_COMP = 1'b1
  } crc_state_e;

endpackage

// File: rtl/sd_crc_step.sv
// Combinational BPC-bit unrolled LFSR update; d_in[BPC-1] is the first bit on the wire.
module sd_crc_step #(
  parameter int unsigned           CRC_W = 7,
  parameter logic [CRC_W-1:0]      POLY  = 7'h09,
  parameter int unsigned           BPC   = 1
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [BPC-1:0]   d_in,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] crc_v;
  logic             fb_v;

  // Serial CRC recurrence applied BPC times, MSB first
  always_comb begin
    crc_v = crc_in;
    fb_v  = 1'b0;
    for (int i = int'(BPC) - 1; i >= 0; i--) begin
      fb_v  = d_in[i] ^ crc_v[CRC_W-1];
      crc_v = {crc_v[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb_v}} & POLY);
    end
    crc_out = crc_v;
  end

endmodule

// File: rtl/sd_crc_engine.sv
// Multi-bit-per-cycle CRC generator/checker: shifts a latched message through
// sd_crc_step over DATA_W/BPC clocks and optionally compares against a received CRC.
module sd_crc_engine
  import sd_crc_pkg::*;
#(
  parameter int unsigned      CRC_W  = 7,
  parameter logic [CRC_W-1:0] POLY   = CRC7_POLY,
  parameter logic [CRC_W-1:0] INIT   = '0,
  parameter int unsigned      DATA_W = SD_CMD_LEN,
  parameter int unsigned      BPC    = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              chk_i,
  input  logic [CRC_W-1:0]  crc_chk_i,
  output logic              busy_o,
  output logic [CRC_W-1:0]  crc_o,
  output logic              crc_valid_o,
  output logic              crc_err_o
);

  localparam int unsigned      N     = DATA_W / BPC;
  localparam int unsigned      CNT_W = (N + 1 > 2) ? $clog2(N + 1) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  if (((DATA_W % BPC) != 0) || (CRC_W < 2)) begin : g_bad_cfg
    $fatal(1, "sd_crc_engine: DATA_W must be a multiple of BPC and CRC_W >= 2");
  end

  crc_state_e        state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [CRC_W-1:0]  crc_chk_q, crc_chk_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              chk_q, chk_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [CRC_W-1:0]  crc_next;

  sd_crc_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .BPC   (BPC)
  ) u_step (
    .crc_in  (crc_q),
    .d_in    (sh_q[DATA_W-1 -: BPC]),
    .crc_out (crc_next)
  );

  // Next-state, datapath and completion pulse; abort beats completion on the last step
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    crc_d     = crc_q;
    crc_chk_d = crc_chk_q;
    cnt_d     = cnt_q;
    chk_d     = chk_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sh_d      = data_i;
          chk_d     = chk_i;
          crc_chk_d = crc_chk_i;
          crc_d     = INIT;
          cnt_d     = '0;
          state_d   = ST_COMP;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_COMP: begin
        if (abort_i) begin
          crc_d   = INIT;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          crc_d = crc_next;
          sh_d  = sh_q << BPC;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            valid_d = 1'b1;
            err_d   = chk_q & (crc_next != crc_chk_q);
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      crc_q     <= '0;
      crc_chk_q <= '0;
      cnt_q     <= '0;
      chk_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      crc_q     <= crc_d;
      crc_chk_q <= crc_chk_d;
      cnt_q     <= cnt_d;
      chk_q     <= chk_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign busy_o      = (state_q == ST_COMP);
  assign crc_o       = crc_q;
  assign crc_valid_o = valid_q;
  assign crc_err_o   = err_q;

endmodule

// File: tb/tb_sd_crc_engine.sv
// Scoreboard bench for three sd_crc_engine configurations (CRC7 x1, CRC7 x8, CRC16 x4),
// reference CRCs computed by polynomial long division.
module tb_sd_crc_engine;

  localparam int NI = 3;
  localparam int NN [NI] = '{40, 5, 18};
  localparam int DW [NI] = '{40, 40, 72};
  localparam int CW [NI] = '{7, 7, 16};
  localparam logic [15:0] PV [NI] = '{16'h0009, 16'h0009, 16'h1021};

  typedef struct {
    logic [15:0] crc;
    logic        err;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_s [NI];
  logic        abort_s [NI];
  logic        chk_s   [NI];
  logic [71:0] data_v  [NI];
  logic [15:0] cchk_v  [NI];
  logic        busy_w  [NI];
  logic        valid_w [NI];
  logic        err_w   [NI];
  logic [6:0]  crc_a, crc_b;
  logic [15:0] crc_c;
  logic [15:0] crc_w   [NI];

  exp_t q [NI][$];
  int   free_c [NI];
  int   acc_last [NI];
  int   nvalid [NI];
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  sd_crc_engine #(.CRC_W(7), .POLY(7'h09), .INIT(7'h00), .DATA_W(40), .BPC(1)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[0]), .abort_i(abort_s[0]),
    .data_i(data_v[0][39:0]), .chk_i(chk_s[0]), .crc_chk_i(cchk_v[0][6:0]),
    .busy_o(busy_w[0]), .crc_o(crc_a), .crc_valid_o(valid_w[0]), .crc_err_o(err_w[0]));

  sd_crc_engine #(.CRC_W(7), .POLY(7'h09), .INIT(7'h00), .DATA_W(40), .BPC(8)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[1]), .abort_i(abort_s[1]),
    .data_i(data_v[1][39:0]), .chk_i(chk_s[1]), .crc_chk_i(cchk_v[1][6:0]),
    .busy_o(busy_w[1]), .crc_o(crc_b), .crc_valid_o(valid_w[1]), .crc_err_o(err_w[1]));

  sd_crc_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'h0000), .DATA_W(72), .BPC(4)) u_c (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[2]), .abort_i(abort_s[2]),
    .data_i(data_v[2]), .chk_i(chk_s[2]), .crc_chk_i(cchk_v[2]),
    .busy_o(busy_w[2]), .crc_o(crc_c), .crc_valid_o(valid_w[2]), .crc_err_o(err_w[2]));

  always_comb begin
    crc_w[0] = {9'd0, crc_a};
    crc_w[1] = {9'd0, crc_b};
    crc_w[2] = crc_c;
  end

  // Remainder of M(x)*x^cw divided by G(x) (seed is zero in every configuration)
  function automatic logic [15:0] ref_crc(input logic [71:0] m, input int dw, input int cw,
                                          input logic [15:0] poly);
    logic [127:0] v;
    logic [127:0] g;
    v = 128'(m) << cw;
    g = (128'd1 << cw) | 128'(poly);
    for (int i = dw + cw - 1; i >= cw; i--)
      if (v[i]) v = v ^ (g << (i - cw));
    return 16'(v & ((128'd1 << cw) - 128'd1));
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference timing model: decides which starts are accepted and queues the expected result
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        q[i].delete();
        free_c[i]   = 0;
        acc_last[i] = -1000;
      end else if (abort_s[i] && cyc > acc_last[i] && cyc <= acc_last[i] + NN[i]) begin
        if (q[i].size() > 0) void'(q[i].pop_back());
        free_c[i]   = cyc + 1;
        acc_last[i] = -1000;
      end else if (start_s[i] && cyc >= free_c[i]) begin
        exp_t e;
        e.crc = ref_crc(data_v[i], DW[i], CW[i], PV[i]);
        e.err = chk_s[i] && (e.crc != (cchk_v[i] & 16'((32'd1 << CW[i]) - 32'd1)));
        e.acc = cyc;
        q[i].push_back(e);
        acc_last[i] = cyc;
        free_c[i]   = cyc + NN[i] + 1;
      end
    end
  end

  // Monitor: every valid pulse must match the head of its scoreboard queue
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        if (valid_w[i] === 1'b1) begin
          nvalid[i]++;
          if (q[i].size() == 0) begin
            chk($sformatf("unexpected_valid%0d", i), 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = q[i].pop_front();
            chk($sformatf("crc%0d", i), 32'(crc_w[i]), 32'(e.crc));
            chk($sformatf("err%0d", i), 32'(err_w[i]), 32'(e.err));
            chk($sformatf("latency%0d", i), 32'(cyc - e.acc), 32'(NN[i]));
          end
        end else begin
          chk($sformatf("err_idle%0d", i), 32'(err_w[i]), 32'd0);
        end
      end
    end
  end

  task automatic go(input int i, input logic [71:0] d, input logic c, input logic [15:0] cc);
    @(negedge clk);
    data_v[i]  = d & ((72'd1 << DW[i]) - 72'd1);
    chk_s[i]   = c;
    cchk_v[i]  = cc;
    start_s[i] = 1'b1;
    @(negedge clk);
    start_s[i] = 1'b0;
  endtask

  task automatic wait_valid(input int i);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (valid_w[i] === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      nvec++;
      nerr++;
      $display("FAIL timeout_valid%0d: got no valid expected valid", i);
    end
  endtask

  task automatic wait_idle(input int i);
    bit done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (busy_w[i] === 1'b0) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      nvec++;
      nerr++;
      $display("FAIL timeout_idle%0d: got busy expected idle", i);
    end
    @(negedge clk);
  endtask

  initial begin
    int nv0;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_s[i] = 1'b0; abort_s[i] = 1'b0; chk_s[i] = 1'b0;
      data_v[i] = '0; cchk_v[i] = '0; nvalid[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
      chk($sformatf("rst_valid%0d", i), 32'(valid_w[i]), 32'd0);
      chk($sformatf("rst_err%0d", i), 32'(err_w[i]), 32'd0);
      chk($sformatf("rst_crc%0d", i), 32'(crc_w[i]), 32'd0);
    end
    rst = 1'b0;
    mon_en = 1'b1;

    go(0, 72'h4000000000, 1'b0, 16'h0); wait_valid(0); chk("cmd0", 32'(crc_w[0]), 32'h4A);
    go(0, 72'h48000001AA, 1'b0, 16'h0); wait_valid(0); chk("cmd8", 32'(crc_w[0]), 32'h43);
    go(0, 72'h5100000000, 1'b0, 16'h0); wait_valid(0); chk("cmd17", 32'(crc_w[0]), 32'h2A);
    go(1, 72'h4000000000, 1'b0, 16'h0); wait_valid(1); chk("cmd0_bpc8", 32'(crc_w[1]), 32'h4A);
    go(2, 72'h313233343536373839, 1'b0, 16'h0); wait_valid(2);
    chk("crc16_123456789", 32'(crc_w[2]), 32'h31C3);

    go(0, 72'h4000000000, 1'b1, 16'h004A); wait_valid(0); chk("chk_ok", 32'(err_w[0]), 32'd0);
    go(0, 72'h4000000000, 1'b1, 16'h004B); wait_valid(0); chk("chk_bad", 32'(err_w[0]), 32'd1);
    @(negedge clk); chk("chk_bad_one_cycle", 32'(err_w[0]), 32'd0);

    // start held high: one result every N+1 clocks
    nv0 = nvalid[0];
    @(negedge clk);
    data_v[0] = 72'h48000001AA; chk_s[0] = 1'b0; start_s[0] = 1'b1;
    repeat (123) @(negedge clk);
    start_s[0] = 1'b0;
    repeat (45) @(negedge clk);
    chk("held_start_count", 32'(nvalid[0] - nv0), 32'd3);

    // start pulsed mid-computation is ignored
    go(0, 72'h4000000000, 1'b0, 16'h0);
    repeat (10) @(negedge clk);
    data_v[0] = 72'h5100000000; start_s[0] = 1'b1;
    @(negedge clk); start_s[0] = 1'b0;
    wait_valid(0); chk("ignored_start", 32'(crc_w[0]), 32'h4A);
    repeat (3) @(negedge clk);

    // abort at step 20
    nv0 = nvalid[0];
    go(0, 72'h4000000000, 1'b0, 16'h0);
    repeat (19) @(negedge clk);
    abort_s[0] = 1'b1;
    @(negedge clk); abort_s[0] = 1'b0;
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_crc_init", 32'(crc_w[0]), 32'd0);
    repeat (50) @(negedge clk);
    chk("abort_no_valid", 32'(nvalid[0] - nv0), 32'd0);

    // reset at step 10
    go(0, 72'h48000001AA, 1'b0, 16'h0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_mid_crc", 32'(crc_w[0]), 32'd0);
    chk("rst_mid_valid", 32'(valid_w[0]), 32'd0);
    go(0, 72'h4000000000, 1'b0, 16'h0); wait_valid(0); chk("cmd0_after_rst", 32'(crc_w[0]), 32'h4A);

    // randomized traffic with occasional aborts
    for (int n = 0; n < 40; n++) begin
      int i;
      logic [71:0] d;
      logic [15:0] r;
      logic        c;
      i = int'($urandom_range(0, NI - 1));
      d = {$urandom, $urandom, $urandom};
      d = d & ((72'd1 << DW[i]) - 72'd1);
      r = ref_crc(d, DW[i], CW[i], PV[i]);
      c = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) r = r ^ 16'(32'd1 << $urandom_range(0, CW[i] - 1));
      go(i, d, c, r);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, NN[i])) @(negedge clk);
        abort_s[i] = 1'b1;
        @(negedge clk); abort_s[i] = 1'b0;
      end
      wait_idle(i);
    end

    repeat (5) @(negedge clk);
    for (int i = 0; i < NI; i++) chk($sformatf("queue_empty%0d", i), 32'(q[i].size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
